// File: rtl/lcd_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_ctrl_pkg : shared types/constants for the HD44780 LCD driver |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package lcd_ctrl_pkg;

  // Bit positions inside the LSU's LCD MMIO register
  localparam int LCD_DATA_LSB = 0;
  localparam int LCD_RW_BIT   = 8;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_EN_BIT   = 10;
  localparam int LCD_ON_BIT   = 31;

  typedef enum logic [2:0] {
    LCD_IDLE  = 3'd0,
    LCD_SETUP = 3'd1,
    LCD_PULSE = 3'd2,
    LCD_HOLD  = 3'd3,
    LCD_EXEC  = 3'd4
  } lcd_state_e;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_cmd_t;

endpackage
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lcd_ctrl : turns CPU LCD-register writes into timed HD44780 bus  |
// | cycles, with a one-deep pending slot. Rev 1.0                    |
// +------------------------------------------------------------------+
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int T_SETUP_CYC = 4,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLR_CYC   = 82000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lcd_vld,
  input  logic [31:0] i_io_lcd,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic        o_busy,
  output logic        o_drop
);

  localparam int CW = $clog2(T_CLR_CYC + 1);

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_EN    = CW'(T_EN_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC_CYC - 1);
  localparam logic [CW-1:0] LD_CLR   = CW'(T_CLR_CYC - 1);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  lcd_cmd_t      bus_q, bus_d;
  lcd_cmd_t      pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          en_q, en_d;
  logic          on_q, on_d;
  logic          drop_q, drop_d;

  lcd_cmd_t      new_cmd;
  logic          cnt_zero;
  logic          long_cmd;
  logic          issue_new;
  logic          consume;
  logic          unused_bits;

  // Software's EN bit and the reserved field are deliberately ignored
  assign unused_bits = ^{i_io_lcd[30:LCD_EN_BIT]};

  assign new_cmd.rs   = i_io_lcd[LCD_RS_BIT];
  assign new_cmd.rw   = i_io_lcd[LCD_RW_BIT];
  assign new_cmd.data = i_io_lcd[LCD_DATA_LSB +: 8];

  assign cnt_zero = (cnt_q == '0);
  // Clear and Return-Home need the long execution wait
  assign long_cmd = !bus_q.rs &&
                    (bus_q.data == 8'h01 || bus_q.data == 8'h02 || bus_q.data == 8'h03);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bus_d     = bus_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    drop_d    = 1'b0;
    on_d      = i_io_lcd[LCD_ON_BIT];
    issue_new = 1'b0;
    consume   = 1'b0;

    case (state_q)
      LCD_IDLE: begin
        cnt_d = '0;
        if (i_lcd_vld) begin
          bus_d     = new_cmd;
          issue_new = 1'b1;
          state_d   = LCD_SETUP;
          cnt_d     = LD_SETUP;
        end
      end
      LCD_SETUP: begin
        if (cnt_zero) begin
          state_d = LCD_PULSE;
          cnt_d   = LD_EN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LCD_PULSE: begin
        if (cnt_zero) begin
          state_d = LCD_HOLD;
          cnt_d   = LD_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LCD_HOLD: begin
        if (cnt_zero) begin
          state_d = LCD_EXEC;
          cnt_d   = long_cmd ? LD_CLR : LD_EXEC;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LCD_EXEC: begin
        if (cnt_zero) begin
          if (pend_v_q) begin
            bus_d   = pend_q;
            consume = 1'b1;
            state_d = LCD_SETUP;
            cnt_d   = LD_SETUP;
          end else if (i_lcd_vld) begin
            bus_d     = new_cmd;
            issue_new = 1'b1;
            state_d   = LCD_SETUP;
            cnt_d     = LD_SETUP;
          end else begin
            state_d = LCD_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = LCD_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (consume) begin
      pend_v_d = 1'b0;
    end

    // A slot being drained this cycle can accept the incoming write
    if (i_lcd_vld && !issue_new) begin
      if (!pend_v_q || consume) begin
        pend_d   = new_cmd;
        pend_v_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end

    en_d = (state_d == LCD_PULSE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= LCD_IDLE;
      cnt_q    <= '0;
      bus_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bus_q    <= bus_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      en_q     <= en_d;
      on_q     <= on_d;
      drop_q   <= drop_d;
    end
  end

  assign o_lcd_data = bus_q.data;
  assign o_lcd_rs   = bus_q.rs;
  assign o_lcd_rw   = bus_q.rw;
  assign o_lcd_en   = en_q;
  assign o_lcd_on   = on_q;
  assign o_drop     = drop_q;
  assign o_busy     = (state_q != LCD_IDLE) || pend_v_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lcd_ctrl : self-checking bench for lcd_ctrl (timeline model)  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_lcd_ctrl;

  localparam int TS = 2;
  localparam int TE = 3;
  localparam int TH = 1;
  localparam int TX = 5;
  localparam int TC = 20;

  logic        clk;
  logic        rst;
  logic        vld;
  logic [31:0] io;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_drop;

  lcd_ctrl #(
    .T_SETUP_CYC(TS), .T_EN_CYC(TE), .T_HOLD_CYC(TH),
    .T_EXEC_CYC(TX), .T_CLR_CYC(TC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_lcd_vld(vld), .i_io_lcd(io),
    .o_lcd_data(o_lcd_data), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
    .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on), .o_busy(o_busy), .o_drop(o_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Timeline model: each issued command owns a fixed window of cycles
  int         cur_end;
  int         en_start;
  int         en_end;
  logic [9:0] m_bus;
  logic [9:0] m_pend;
  bit         m_pend_v;
  bit         m_drop;
  bit         m_on;

  // Observation helpers
  bit         prev_en;
  int         rise_cyc[$];
  logic [7:0] rise_dat[$];
  int         n_drops;

  typedef struct {
    bit          vld;
    logic [31:0] io;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[12];

  wire [13:0] act = {o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_busy, o_drop};

  function automatic logic [13:0] pk(logic [7:0] d, logic rs, logic rw, logic en,
                                     logic on, logic busy, logic drop);
    return {d, rs, rw, en, on, busy, drop};
  endfunction

  task automatic check(string name, logic [31:0] a, logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, a, e);
    end
  endtask

  function automatic bit is_clr(logic [9:0] c);
    return (c[9] == 1'b0) && (c[7:0] == 8'h01 || c[7:0] == 8'h02 || c[7:0] == 8'h03);
  endfunction

  task automatic model_reset();
    cur_end  = -1;
    en_start = -1;
    en_end   = -1;
    m_bus    = '0;
    m_pend   = '0;
    m_pend_v = 1'b0;
    m_drop   = 1'b0;
    m_on     = 1'b0;
  endtask

  task automatic issue(int s, logic [9:0] c);
    m_bus    = c;
    en_start = s + 1 + TS;
    en_end   = s + TS + TE;
    cur_end  = s + TS + TE + TH + (is_clr(c) ? TC : TX);
  endtask

  task automatic model_update(int c, bit v, logic [31:0] d);
    m_drop = 1'b0;
    m_on   = d[31];
    if (v) begin
      if (c > cur_end) begin
        issue(c, d[9:0]);
      end else if (c == cur_end) begin
        if (m_pend_v) begin
          issue(c, m_pend);
          m_pend = d[9:0];
        end else begin
          issue(c, d[9:0]);
        end
      end else if (!m_pend_v) begin
        m_pend   = d[9:0];
        m_pend_v = 1'b1;
      end else begin
        m_drop = 1'b1;
      end
    end else if (c == cur_end && m_pend_v) begin
      issue(c, m_pend);
      m_pend_v = 1'b0;
    end
  endtask

  function automatic logic [13:0] model_exp(int c);
    return pk(m_bus[7:0], m_bus[9], m_bus[8], (c >= en_start && c <= en_end),
              m_on, (c <= cur_end), m_drop);
  endfunction

  // One clock: drive, advance model, then compare on the falling edge
  task automatic step(bit v, logic [31:0] d);
    vld = v;
    io  = d;
    @(posedge clk);
    model_update(cyc, v, d);
    cyc++;
    @(negedge clk);
    check("model", {18'h0, act}, {18'h0, model_exp(cyc)});
    if (o_lcd_en && !prev_en) begin
      rise_cyc.push_back(cyc);
      rise_dat.push_back(o_lcd_data);
    end
    prev_en = o_lcd_en;
    if (o_drop) n_drops++;
  endtask

  task automatic clear_obs();
    rise_cyc.delete();
    rise_dat.delete();
    n_drops = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (o_busy && k < 200) begin
      step(1'b0, 32'h0);
      k++;
    end
    if (o_busy) check("idle_timeout", 32'(o_busy), 32'h0);
    step(1'b0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0;
    prev_en = 1'b0;
    clear_obs();
    model_reset();
    rst = 1'b1;
    vld = 1'b0;
    io  = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_state", {18'h0, act}, 32'h0);
    rst = 1'b0;

    // Single write 'A' with RS=1, checked against hand-derived cycle table
    tbl[0]  = '{1'b1, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 1, 0)};
    tbl[1]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 1, 0)};
    tbl[2]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 1, 0, 1, 0)};
    tbl[3]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 1, 0, 1, 0)};
    tbl[4]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 1, 0, 1, 0)};
    tbl[5]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 1, 0)};
    tbl[6]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 1, 0)};
    tbl[7]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 1, 0)};
    tbl[8]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 1, 0)};
    tbl[9]  = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 1, 0)};
    tbl[10] = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 1, 0)};
    tbl[11] = '{1'b0, 32'h0000_0241, pk(8'h41, 1, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].vld, tbl[i].io);
      check("table", {18'h0, act}, {18'h0, tbl[i].exp});
    end

    // Clear: long exec, second write parked at the 15th EXEC cycle
    wait_idle();
    clear_obs();
    c0 = cyc;
    step(1'b1, 32'h0000_0001);
    for (int k = 0; k < 40; k++) begin
      if (cyc == c0 + 21) step(1'b1, 32'h0000_0245);
      else                step(1'b0, 32'h0);
    end
    check("clr_pulses", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2) begin
      check("clr_first_en", rise_cyc[0], c0 + 1 + TS);
      check("clr_second_en", rise_cyc[1], c0 + 29);
      check("clr_second_dat", rise_dat[1], 8'h45);
    end

    // Burst of three: oldest pending wins, third is dropped
    wait_idle();
    clear_obs();
    step(1'b1, 32'h0000_0231);
    step(1'b1, 32'h0000_0232);
    step(1'b1, 32'h0000_0233);
    repeat (40) step(1'b0, 32'h0);
    check("burst_drops", n_drops, 1);
    check("burst_pulses", rise_cyc.size(), 2);
    if (rise_cyc.size() == 2) check("burst_second_dat", rise_dat[1], 8'h32);

    // Refill in the last EXEC cycle while the slot is full
    wait_idle();
    clear_obs();
    c0 = cyc;
    step(1'b1, 32'h0000_0241);
    step(1'b1, 32'h0000_0242);
    while (cyc < c0 + 11) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0243);
    repeat (30) step(1'b0, 32'h0);
    check("refill_drops", n_drops, 0);
    check("refill_pulses", rise_cyc.size(), 3);
    if (rise_cyc.size() == 3) begin
      check("refill_en0", rise_cyc[0], c0 + 3);
      check("refill_en1", rise_cyc[1], c0 + 14);
      check("refill_en2", rise_cyc[2], c0 + 25);
      check("refill_order", {rise_dat[0], rise_dat[1], rise_dat[2]}, 24'h414243);
    end

    // Software EN and ON bits
    wait_idle();
    clear_obs();
    c0 = cyc;
    step(1'b1, 32'h8000_0441);
    check("sw_on", 32'(o_lcd_on), 32'h1);
    check("sw_en_ignored", 32'(o_lcd_en), 32'h0);
    repeat (12) step(1'b0, 32'h8000_0441);
    check("sw_pulses", rise_cyc.size(), 1);
    if (rise_cyc.size() == 1) check("sw_en_rise", rise_cyc[0], c0 + 3);

    // Reset while EN is high
    wait_idle();
    clear_obs();
    step(1'b1, 32'h0000_0241);
    repeat (3) step(1'b0, 32'h0);
    check("pre_rst_en", 32'(o_lcd_en), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_en", 32'(o_lcd_en), 32'h0);
    check("async_rst_all", {18'h0, act}, 32'h0);
    #1 rst = 1'b0;
    model_reset();
    prev_en = 1'b0;
    clear_obs();
    step(1'b1, 32'h0000_0248);
    repeat (14) step(1'b0, 32'h0);
    check("post_rst_pulses", rise_cyc.size(), 1);
    check("post_rst_idle", 32'(o_busy), 32'h0);

    // Randomized traffic against the timeline model
    for (int k = 0; k < 1500; k++) begin
      logic [31:0] d;
      bit v;
      v = ($urandom_range(0, 5) == 0);
      d = $urandom;
      d[30:11] = '0;
      if ($urandom_range(0, 3) == 0) begin
        d[9]   = 1'b0;
        d[7:0] = 8'($urandom_range(1, 3));
      end
      step(v, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
